// File: rtl/s2mm_pkg.sv
// Shared types and helpers for the s2mm packet arbiter and its round-robin search.
package s2mm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Upper bound on requesters handled by the generic round-robin search.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_grant_t;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester at or after ptr, wrapping modulo num.
  function automatic rr_grant_t rr_next_grant(input logic [RR_MAX_REQ-1:0] req,
                                              input int num, input int ptr);
    rr_grant_t g;
    int        c;
    g = '0;
    // Walk offsets from far to near so the requester closest to ptr wins.
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        c = ptr + k;
        if (c >= num) c = c - num;
        if (req[c[RR_IDX_W-1:0]]) begin
          g.valid = 1'b1;
          g.idx   = c[RR_IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/s2mm_packet_arbiter_rr_arbiter.sv
// Combinational round-robin search: one-hot grant plus encoded index, starting at i_ptr.
module rr_arbiter
  import s2mm_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = ch_idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  rr_grant_t w_g;

  // Priority search from the pointer and one-hot decode of the winner.
  always_comb begin
    // NOTE: every output gets a default before any conditional write so no latch is inferred.
    o_grant = '0;
    w_g     = rr_next_grant(RR_MAX_REQ'(i_req), N, int'(i_ptr));
    o_valid = w_g.valid;
    o_idx   = IDX_W'(w_g.idx);
    if (w_g.valid) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/s2mm_packet_arbiter.sv
// Assembles per-channel FIFO words into AXI-Stream packets, round-robin per packet.
module s2mm_packet_arbiter
  import s2mm_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_FIFOS       = 2,
  parameter int PKT_LEN_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  output logic [NUM_FIFOS-1:0]                 fifo_rden,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_FIFOS*PKT_LEN_WIDTH-1:0]   pkt_len,
  output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]         DST_AXIS_tkeep,
  output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest,
  output logic                                 DST_AXIS_tlast,
  output logic                                 DST_AXIS_tvalid,
  input  logic                                 DST_AXIS_tready,
  output logic                                 busy,
  output logic [AXIS_DEST_WIDTH-1:0]           cur_ch
);

  localparam int CH_W = ch_idx_width(NUM_FIFOS);

  state_t                       r_state, w_state_next;
  logic [CH_W-1:0]              r_rr_ptr, r_cur_ch;
  logic [PKT_LEN_WIDTH-1:0]     r_count, r_len;
  logic [AXIS_DATA_WIDTH-1:0]   r_tdata;
  logic [AXIS_DEST_WIDTH-1:0]   r_tdest;
  logic                         r_tlast, r_tvalid;

  logic [NUM_FIFOS-1:0]         w_req, w_grant_onehot;
  logic [CH_W-1:0]              w_grant_idx;
  logic                         w_grant_valid;
  logic [PKT_LEN_WIDTH-1:0]     w_grant_len;
  logic [FIFO_DATA_WIDTH-1:0]   w_head_data;
  logic                         w_head_empty, w_load_en, w_pop, w_last;

  assign w_req     = ~fifo_empty;
  assign w_load_en = !r_tvalid || DST_AXIS_tready;
  assign w_last    = (r_count == r_len - 1'b1);

  rr_arbiter #(.N(NUM_FIFOS), .IDX_W(CH_W)) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_onehot),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_valid)
  );

  // Select the granted channel's length word and the current channel's FIFO head.
  always_comb begin
    w_grant_len  = '0;
    w_head_data  = '0;
    w_head_empty = 1'b1;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (w_grant_onehot[i]) w_grant_len = pkt_len[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
      if (r_cur_ch == CH_W'(i)) begin
        w_head_data  = fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
        w_head_empty = fifo_empty[i];
      end
    end
  end

  // Next-state and pop decision; pops never happen in IDLE or under reset.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    fifo_rden    = '0;
    case (r_state)
      ST_IDLE: if (w_grant_valid) w_state_next = ST_XFER;
      ST_XFER: begin
        if (rstn && w_load_en && !w_head_empty) begin
          w_pop = 1'b1;
          if (w_last) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_FIFOS; i++) fifo_rden[i] = w_pop && (r_cur_ch == CH_W'(i));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Grant bookkeeping: channel, latched length, word count and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
      r_cur_ch <= '0;
      r_len    <= '0;
      r_count  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_grant_valid) begin
        r_cur_ch <= w_grant_idx;
        r_len    <= (w_grant_len == '0) ? PKT_LEN_WIDTH'(1) : w_grant_len;
        r_count  <= '0;
      end
    end else if (w_pop) begin
      if (w_last) r_rr_ptr <= (r_cur_ch == CH_W'(NUM_FIFOS - 1)) ? '0 : r_cur_ch + 1'b1;
      else        r_count  <= r_count + 1'b1;
    end
  end

  // Output skid-free register: load on pop, drop valid when a slot frees with nothing to load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tdest  <= '0;
    end else if (w_pop) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_last;
      r_tdata  <= AXIS_DATA_WIDTH'(w_head_data);
      r_tdest  <= AXIS_DEST_WIDTH'(r_cur_ch);
    end else if (w_load_en) begin
      r_tvalid <= 1'b0;
    end
  end

  assign DST_AXIS_tdata  = r_tdata;
  assign DST_AXIS_tkeep  = '1;
  assign DST_AXIS_tdest  = r_tdest;
  assign DST_AXIS_tlast  = r_tlast;
  assign DST_AXIS_tvalid = r_tvalid;
  assign busy            = (r_state == ST_XFER);
  assign cur_ch          = AXIS_DEST_WIDTH'(r_cur_ch);

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Self-checking bench: FIFOs as queues, a packet-level model checked every cycle, plus directed literals.
module tb_s2mm_packet_arbiter;

  localparam int N = 2, DW = 32, FDW = 32, DESTW = 4, PLW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       fifo_rden, fifo_empty;
  logic [N*FDW-1:0]   fifo_data;
  logic [N*PLW-1:0]   pkt_len;
  logic [DW-1:0]      tdata;
  logic [DW/8-1:0]    tkeep;
  logic [DESTW-1:0]   tdest, cur_ch;
  logic               tlast, tvalid, tready, busy;

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DATA_WIDTH(FDW), .AXIS_DEST_WIDTH(DESTW),
    .NUM_FIFOS(N), .PKT_LEN_WIDTH(PLW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .pkt_len(pkt_len),
    .DST_AXIS_tdata(tdata), .DST_AXIS_tkeep(tkeep), .DST_AXIS_tdest(tdest),
    .DST_AXIS_tlast(tlast), .DST_AXIS_tvalid(tvalid), .DST_AXIS_tready(tready),
    .busy(busy), .cur_ch(cur_ch)
  );

  typedef struct {
    logic [31:0] data;
    int          dest;
    bit          last;
    int          cyc;
  } beat_t;

  int          n_err = 0, n_chk = 0, cyc = 0, pushed = 0;
  logic [31:0] q[N][$];
  bit          pend_pop[N];
  beat_t       log_q[$];

  // Packet-level model state.
  int          m_ptr = 0, m_ch = 0, m_cur = 0, m_left = 0, m_odest = 0;
  bit          m_busy = 0, m_ov = 0, m_ol = 0;
  logic [31:0] m_od = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]          = (q[i].size() == 0);
      fifo_data[i*FDW +: FDW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    q[ch].push_back(d);
    pushed++;
    refresh();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_pop[i]) begin
        void'(q[i].pop_front());
        pend_pop[i] = 0;
      end
    end
    refresh();
    cyc++;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (log_q.size() < target && n < budget) begin
      cycle();
      n++;
    end
    check(name, 64'(log_q.size() >= target), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  task automatic set_len(input int ch, input int len);
    pkt_len[ch*PLW +: PLW] = PLW'(len);
  endtask

  // Compare DUT against the model each cycle, then advance the model by one clock.
  always @(negedge clk) begin : compare_model
    logic [N-1:0] exp_rden;
    bit           load, was_busy;
    int           c, len;
    load     = !m_ov || tready;
    exp_rden = '0;
    if (rstn && m_busy && load && q[m_ch].size() != 0) exp_rden[m_ch] = 1'b1;

    check("tvalid", 64'(tvalid), 64'(m_ov));
    if (m_ov) begin
      check("tdata", 64'(tdata), 64'(m_od));
      check("tdest", 64'(tdest), 64'(m_odest));
      check("tlast", 64'(tlast), 64'(m_ol));
      check("tkeep", 64'(tkeep), 64'hF);
    end
    check("busy", 64'(busy), 64'(m_busy));
    check("cur_ch", 64'(cur_ch), 64'(m_cur));
    check("fifo_rden", 64'(fifo_rden), 64'(exp_rden));

    if (tvalid && tready) log_q.push_back('{data: tdata, dest: int'(tdest), last: tlast, cyc: cyc});

    if (!rstn) begin
      m_ptr = 0; m_ch = 0; m_cur = 0; m_left = 0;
      m_busy = 0; m_ov = 0; m_ol = 0;
    end else begin
      was_busy = m_busy;
      if (exp_rden != '0) begin
        m_ov    = 1;
        m_od    = q[m_ch][0];
        m_odest = m_ch;
        m_ol    = (m_left == 1);
        pend_pop[m_ch] = 1;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_ptr  = (m_ch + 1) % N;
        end
      end else if (load) begin
        m_ov = 0;
      end
      if (!was_busy) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!m_busy && q[c].size() != 0) begin
            len    = int'(pkt_len[c*PLW +: PLW]);
            m_ch   = c;
            m_cur  = c;
            m_left = (len == 0) ? 1 : len;
            m_busy = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int base, t0, cnt, p;
    tready  = 1'b1;
    pkt_len = '0;
    refresh();
    repeat (3) cycle();
    check("reset_tvalid", 64'(tvalid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cur_ch", 64'(cur_ch), 64'd0);
    check("reset_tdata", 64'(tdata), 64'd0);
    check("reset_tdest", 64'(tdest), 64'd0);
    rstn = 1'b1;
    cycle();

    // Single channel, four words, latency from grant.
    set_len(0, 4);
    base = log_q.size();
    t0   = cyc;
    for (int i = 0; i < 4; i++) push(0, 32'h10 + i);
    wait_beats(base + 4, 40, "s1_done");
    check("s1_latency", 64'(log_q[base].cyc - t0), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("s1_data", 64'(log_q[base+i].data), 64'(32'h10 + i));
      check("s1_dest", 64'(log_q[base+i].dest), 64'd0);
      check("s1_last", 64'(log_q[base+i].last), 64'(i == 3));
    end
    repeat (3) cycle();

    // Two full FIFOs, two-word packets alternate ch0, ch1.
    do_reset();
    set_len(0, 2);
    set_len(1, 2);
    base = log_q.size();
    for (int k = 0; k < 8; k++) begin
      push(0, 32'h100 + k);
      push(1, 32'h200 + k);
    end
    wait_beats(base + 16, 100, "s2_done");
    for (int i = 0; i < 16; i++) begin
      p = i / 2;
      check("s2_dest", 64'(log_q[base+i].dest), 64'(p % 2));
      check("s2_last", 64'(log_q[base+i].last), 64'(i % 2 == 1));
      check("s2_data", 64'(log_q[base+i].data),
            64'(((p % 2) == 0 ? 32'h100 : 32'h200) + (p / 2) * 2 + (i % 2)));
    end
    repeat (3) cycle();

    // Backpressure mid-packet: nothing popped, nothing lost.
    set_len(0, 4);
    base = log_q.size();
    for (int i = 0; i < 4; i++) push(0, 32'h300 + i);
    wait_beats(base + 1, 20, "s3_first");
    tready = 1'b0;
    repeat (5) begin
      cycle();
      check("s3_rden_stall", 64'(fifo_rden), 64'd0);
    end
    tready = 1'b1;
    wait_beats(base + 4, 40, "s3_done");
    check("s3_count", 64'(log_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) check("s3_data", 64'(log_q[base+i].data), 64'(32'h300 + i));
    repeat (3) cycle();

    // FIFO0 runs dry mid-packet; ch1 must not be granted meanwhile.
    do_reset();
    set_len(0, 4);
    set_len(1, 4);
    base = log_q.size();
    push(0, 32'h400);
    push(0, 32'h401);
    for (int i = 0; i < 4; i++) push(1, 32'h500 + i);
    for (int n = 0; n < 50 && q[0].size() != 0; n++) cycle();
    repeat (3) begin
      cycle();
      check("s4_busy_wait", 64'(busy), 64'd1);
      check("s4_cur_ch_wait", 64'(cur_ch), 64'd0);
    end
    push(0, 32'h402);
    push(0, 32'h403);
    wait_beats(base + 8, 60, "s4_done");
    for (int i = 0; i < 8; i++) begin
      check("s4_dest", 64'(log_q[base+i].dest), 64'(i / 4));
      check("s4_last", 64'(log_q[base+i].last), 64'(i % 4 == 3));
    end
    for (int i = 0; i < 4; i++) check("s4_data", 64'(log_q[base+i].data), 64'(32'h400 + i));
    repeat (3) cycle();

    // Zero length means a one-word packet.
    set_len(1, 0);
    base = log_q.size();
    push(1, 32'h600);
    wait_beats(base + 1, 20, "s5_done");
    check("s5_data", 64'(log_q[base].data), 64'h600);
    check("s5_dest", 64'(log_q[base].dest), 64'd1);
    check("s5_last", 64'(log_q[base].last), 64'd1);
    repeat (4) cycle();
    check("s5_single", 64'(log_q.size() - base), 64'd1);
    check("s5_idle", 64'(busy), 64'd0);

    // Reset on beat two abandons the packet; the next one restarts at ch0.
    set_len(0, 4);
    base = log_q.size();
    for (int i = 0; i < 4; i++) push(0, 32'h700 + i);
    wait_beats(base + 2, 20, "s6_two");
    rstn = 1'b0;
    cycle();
    check("s6_rst_tvalid", 64'(tvalid), 64'd0);
    check("s6_rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) push(0, 32'h710 + i);
    wait_beats(base + 4, 40, "s6_restart");
    check("s6_d0", 64'(log_q[base].data), 64'h703);
    check("s6_d3", 64'(log_q[base+3].data), 64'h712);
    for (int i = 0; i < 4; i++) begin
      check("s6_dest", 64'(log_q[base+i].dest), 64'd0);
      check("s6_last", 64'(log_q[base+i].last), 64'(i == 3));
    end
    for (int i = 0; i < 3; i++) push(0, 32'h714 + i);
    wait_beats(base + 8, 40, "s6_drain");
    check("s6_last2", 64'(log_q[base+7].last), 64'd1);
    repeat (3) cycle();

    // Randomized traffic, lengths and backpressure against the model.
    do_reset();
    base = log_q.size();
    t0   = pushed;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(2) == 0 && q[ch].size() < 16) push(ch, $urandom);
        if ($urandom_range(19) == 0) set_len(ch, int'($urandom_range(5)));
      end
      tready = ($urandom_range(3) != 0);
      cycle();
    end
    tready = 1'b1;
    cnt = 0;
    while (cnt < 2000 && (m_busy || m_ov || q[0].size() != 0 || q[1].size() != 0)) begin
      if (m_busy && q[m_ch].size() == 0) push(m_ch, $urandom);
      cycle();
      cnt++;
    end
    check("rand_drained", 64'(cnt < 2000), 64'd1);
    check("rand_conserve", 64'(log_q.size() - base), 64'(pushed - t0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/s2mm_packet_arbiter.md
Name: s2mm_packet_arbiter

Overview:
Downstream-side counterpart of the mm2s routing stage. Collects result words from NUM_FIFOS accelerator output FIFOs and assembles them into AXI-Stream packets for the MCDMA s2mm slave port. Each packet carries the source channel index on tdest and asserts tlast on its final word. Channels are selected round-robin at packet granularity, and packets are never interleaved.

Parameters:
AXIS_DATA_WIDTH, 32, width of DST_AXIS_tdata
FIFO_DATA_WIDTH, 32, width of each FIFO data word; must be <= AXIS_DATA_WIDTH, zero-extended on output
AXIS_DEST_WIDTH, 4, width of tdest; 2**AXIS_DEST_WIDTH >= NUM_FIFOS
NUM_FIFOS, 2, number of source FIFOs / MCDMA s2mm channels
PKT_LEN_WIDTH, 16, width of each per-channel packet-length word

Ports:
clk  in  1  single clock for all logic
rstn  in  1  synchronous, active-low reset
fifo_rden  out  NUM_FIFOS  per-FIFO pop strobe
fifo_empty  in  NUM_FIFOS  per-FIFO empty flag
fifo_data  in  NUM_FIFOS*FIFO_DATA_WIDTH  flattened FWFT head words; channel i at [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]
pkt_len  in  NUM_FIFOS*PKT_LEN_WIDTH  words per packet for each channel, flattened the same way
DST_AXIS_tdata  out  AXIS_DATA_WIDTH  packet data to MCDMA s2mm
DST_AXIS_tkeep  out  AXIS_DATA_WIDTH/8  all ones whenever tvalid is high
DST_AXIS_tdest  out  AXIS_DEST_WIDTH  source channel index
DST_AXIS_tlast  out  1  last word of packet
DST_AXIS_tvalid  out  1  output word valid
DST_AXIS_tready  in  1  MCDMA ready
busy  out  1  high while a packet is in progress (state XFER)
cur_ch  out  AXIS_DEST_WIDTH  channel currently granted; holds its last value in IDLE

Behaviour:
- Clocking and reset: everything is synchronous to clk. A sampled rstn=0 forces:
  - state to IDLE, rr_ptr to 0, word count to 0
  - tvalid, tlast, fifo_rden and busy to 0; tdata, tdest and cur_ch to 0
- Reset mid-packet abandons the partial packet with no tlast. The MCDMA must be reset alongside this block.
- FIFO interface:
  - FIFOs are first-word-fall-through: fifo_data[i] is valid whenever fifo_empty[i]=0.
  - fifo_rden[i]=1 pops that word in the same cycle.
  - fifo_rden is combinational and is never asserted while fifo_empty[i]=1.
- Output register: one stage holding tdata, tdest, tlast and tvalid.
  - load_en = !tvalid || tready.
  - A word is transferred when tvalid && tready.
  - tdata, tdest and tlast stay stable while tvalid=1 and tready=0.
- State IDLE:
  - Scans channels starting at rr_ptr, wrapping modulo NUM_FIFOS.
  - The first channel with fifo_empty=0 is granted: register cur_ch, latch len = (pkt_len[ch]==0 ? 1 : pkt_len[ch]), clear count, go to XFER.
  - No FIFO is popped in IDLE.
  - If every FIFO is empty, stay in IDLE.
- State XFER:
  - Each cycle with load_en=1 and fifo_empty[cur_ch]=0: pop the FIFO, load the output register with {zero-extended data, tdest=cur_ch, tlast=(count==len-1)}, and set tvalid=1.
  - If count==len-1, go to IDLE and set rr_ptr = cur_ch+1 (wrapping); otherwise increment count.
  - If load_en=1 but the FIFO is empty, tvalid drops to 0 (after any pending transfer) and the block waits in XFER. There is no tlast and no channel switch.
- IDLE is re-entered with the final word possibly still held in the output register. The next grant can be made while that word waits. The first pop of the next packet only occurs when load_en=1.
- Latency: with tready=1 and data present:
  - grant in cycle N
  - first pop in N+1
  - first word valid in N+2
  - sustained rate of 1 word/cycle within a packet
  - one bubble cycle between packets
- pkt_len is sampled only at grant. Changes mid-packet take effect from the next packet.
- count and len are PKT_LEN_WIDTH wide. The maximum packet is 2**PKT_LEN_WIDTH-1 words.

Decomposition:
- Package s2mm_pkg holds:
  - the state encoding (IDLE, XFER)
  - a function clog2-based channel-index width
  - a round-robin next-grant function (request vector, pointer) -> index/valid
- Natural sub-module: rr_arbiter. Combinational priority search starting at rr_ptr, giving a one-hot grant plus an encoded index. It is reusable by other multi-channel blocks.

Test Plan:
- Single channel, pkt_len[0]=4, FIFO0 preloaded with 0x10..0x13, tready=1 -> four beats 0x10..0x13 with tdest=0 and tlast only on 0x13; first beat two cycles after the grant.
- Both FIFOs hold 8 words, pkt_len=2 each -> packet order ch0, ch1, ch0, ch1; each packet has 2 beats, and tdest matches the source on every beat.
- tready held low for 5 cycles mid-packet -> tdata, tdest and tlast stay stable; fifo_rden=0 during the stall; no words lost or duplicated.
- FIFO0 runs empty after 2 of 4 words, refilled 3 cycles later -> tvalid drops, no tlast, ch1 is not granted while it waits; the packet resumes and tlast falls on word 4.
- pkt_len[1]=0 with ch1 non-empty -> a single-word packet with tlast=1 and tdest=1.
- rstn=0 asserted on beat 2 of 4 -> next cycle tvalid=0, busy=0, rr_ptr=0; after release, a new packet starts from ch0 with count restarted.
